// File: rtl/md_audio_decim.sv
// Box-car decimator for the YM2612/PSG mix: averages 2^DECIM_LOG2 stereo samples,
// applies a 2^gain/4 scale, saturates to 16 bits and offers the result on valid/ready.
module md_audio_decim #(
    parameter int DECIM_LOG2 = 10
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [17:0] in_l,
    input  logic [17:0] in_r,
    input  logic [1:0]  gain,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam int ACC_W = 18 + DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

    logic [DECIM_LOG2-1:0]   cnt;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] in_l_ext;
    logic signed [ACC_W-1:0] in_r_ext;
    logic signed [ACC_W-1:0] sum_l;
    logic signed [ACC_W-1:0] sum_r;
    logic [15:0]             sat_l;
    logic [15:0]             sat_r;
    logic                    window_end;
    logic                    transfer;

    // The shifted average is kept 22 bits wide so a full-scale average at gain=3
    // cannot wrap; bounds are compared before the final >>>2 so floor is preserved.
    function automatic logic [15:0] scale_sat(input logic [17:0] avg, input logic [1:0] g);
        logic signed [21:0] prod;
        prod = {{4{avg[17]}}, avg};
        prod = prod <<< g;
        if (prod > 22'sd131071) begin
            return 16'h7FFF;
        end else if (prod < -22'sd131072) begin
            return 16'h8000;
        end else begin
            return prod[17:2];
        end
    endfunction

    always_comb begin
        in_l_ext   = {{DECIM_LOG2{in_l[17]}}, in_l};
        in_r_ext   = {{DECIM_LOG2{in_r[17]}}, in_r};
        sum_l      = acc_l + in_l_ext;
        sum_r      = acc_r + in_r_ext;
        window_end = (cnt == CNT_LAST);
        transfer   = out_valid & out_ready;
        sat_l      = scale_sat(sum_l[ACC_W-1:DECIM_LOG2], gain);
        sat_r      = scale_sat(sum_r[ACC_W-1:DECIM_LOG2], gain);
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            cnt   <= '0;
            acc_l <= '0;
            acc_r <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt == '0) begin
                acc_l <= in_l_ext;
                acc_r <= in_r_ext;
            end else begin
                acc_l <= sum_l;
                acc_r <= sum_r;
            end
        end
    end

    // A new window result always wins over a pending one; losing an untaken sample is flagged.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (window_end) begin
            out_l     <= sat_l;
            out_r     <= sat_r;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_md_audio_decim.sv
// Scoreboard bench for md_audio_decim: directed windows on a DECIM_LOG2=2 instance
// and an alternating full-scale pattern on a DECIM_LOG2=10 instance.
module tb_md_audio_decim;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } sample_t;

    logic        MCLK = 1'b0;
    logic        rst_a = 1'b1;
    logic [17:0] a_in_l = '0;
    logic [17:0] a_in_r = '0;
    logic [1:0]  a_gain = '0;
    logic        a_ready = 1'b0;
    logic [15:0] a_out_l;
    logic [15:0] a_out_r;
    logic        a_valid;
    logic        a_overrun;

    logic        rst_b = 1'b1;
    logic [17:0] b_in_l = '0;
    logic [17:0] b_in_r = '0;
    logic [1:0]  b_gain = '0;
    logic        b_ready = 1'b0;
    logic [15:0] b_out_l;
    logic [15:0] b_out_r;
    logic        b_valid;
    logic        b_overrun;

    int checks = 0;
    int errors = 0;
    sample_t qa[$];
    sample_t qb[$];
    sample_t exp_a;
    sample_t exp_b;

    md_audio_decim #(.DECIM_LOG2(2)) dut_a (
        .MCLK(MCLK), .reset(rst_a), .in_l(a_in_l), .in_r(a_in_r), .gain(a_gain),
        .out_l(a_out_l), .out_r(a_out_r), .out_valid(a_valid), .out_ready(a_ready),
        .overrun(a_overrun)
    );

    md_audio_decim #(.DECIM_LOG2(10)) dut_b (
        .MCLK(MCLK), .reset(rst_b), .in_l(b_in_l), .in_r(b_in_r), .gain(b_gain),
        .out_l(b_out_l), .out_r(b_out_r), .out_valid(b_valid), .out_ready(b_ready),
        .overrun(b_overrun)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitors pop one expected sample per handshake transfer, mid-cycle.
    always @(negedge MCLK) begin
        if (!rst_a && a_valid && a_ready) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("[TB] FAIL mon_a_extra: got l=%0d r=%0d, expected no transfer",
                         $signed(a_out_l), $signed(a_out_r));
            end else begin
                exp_a = qa.pop_front();
                if (a_out_l !== exp_a.l || a_out_r !== exp_a.r) begin
                    errors++;
                    $display("[TB] FAIL mon_a_sample: got l=%0d r=%0d, expected l=%0d r=%0d",
                             $signed(a_out_l), $signed(a_out_r), $signed(exp_a.l), $signed(exp_a.r));
                end
            end
        end
    end

    always @(negedge MCLK) begin
        if (!rst_b && b_valid && b_ready) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("[TB] FAIL mon_b_extra: got l=%0d r=%0d, expected no transfer",
                         $signed(b_out_l), $signed(b_out_r));
            end else begin
                exp_b = qb.pop_front();
                if (b_out_l !== exp_b.l || b_out_r !== exp_b.r) begin
                    errors++;
                    $display("[TB] FAIL mon_b_sample: got l=%0d r=%0d, expected l=%0d r=%0d",
                             $signed(b_out_l), $signed(b_out_r), $signed(exp_b.l), $signed(exp_b.r));
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input int l, input int r, input int g, input int rdy);
        a_in_l  = 18'(l);
        a_in_r  = 18'(r);
        a_gain  = 2'(g);
        a_ready = rdy[0];
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_a(input int l, input int r);
        qa.push_back('{16'(l), 16'(r)});
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick(1);
        checkOutput("rst_out_l", $signed(a_out_l), 0);
        checkOutput("rst_out_r", $signed(a_out_r), 0);
        checkOutput("rst_valid", int'(a_valid), 0);
        checkOutput("rst_overrun", int'(a_overrun), 0);
        rst_a = 1'b0;
    endtask

    initial begin
        // Constant input, ready held high: one valid pulse per window.
        reset_a();
        applyStimulus(1000, 1000, 0, 1);
        for (int k = 0; k <= 12; k++) begin
            if (k % 4 == 0 && k < 12) push_a(250, 250);
            tick(1);
            checkOutput("t1_valid", int'(a_valid), ((k + 1) % 4 == 0) ? 1 : 0);
            checkOutput("t1_overrun", int'(a_overrun), 0);
        end

        // Saturation, small value, floor rounding, gain sampled only at window end.
        reset_a();
        push_a(32767, -32768);
        applyStimulus(131071, -131072, 3, 1);
        tick(4);
        checkOutput("t2_valid_sat", int'(a_valid), 1);
        push_a(4, 0);
        applyStimulus(4, 0, 2, 1);
        tick(4);
        push_a(-1, 0);
        applyStimulus(-1, 0, 2, 1);
        tick(1);
        applyStimulus(0, 0, 2, 1);
        tick(3);
        push_a(-1, 0);
        applyStimulus(-1, 0, 0, 1);
        tick(1);
        applyStimulus(0, 0, 0, 1);
        tick(3);
        push_a(250, 250);
        applyStimulus(1000, 1000, 3, 1);
        tick(3);
        applyStimulus(1000, 1000, 0, 1);
        tick(1);
        push_a(2000, 2000);
        applyStimulus(1000, 1000, 0, 1);
        tick(3);
        applyStimulus(1000, 1000, 3, 1);
        tick(1);
        checkOutput("t3_valid_late_gain", int'(a_valid), 1);
        tick(1);

        // Backpressure with an overwrite, then a late transfer.
        reset_a();
        applyStimulus(1000, 400, 0, 0);
        tick(4);
        checkOutput("t4_valid_c4", int'(a_valid), 1);
        checkOutput("t4_out_l_c4", $signed(a_out_l), 250);
        checkOutput("t4_out_r_c4", $signed(a_out_r), 100);
        checkOutput("t4_overrun_c4", int'(a_overrun), 0);
        applyStimulus(2000, 400, 0, 0);
        tick(1);
        checkOutput("t4_valid_c5", int'(a_valid), 1);
        checkOutput("t4_out_l_c5", $signed(a_out_l), 250);
        tick(3);
        checkOutput("t4_out_l_c8", $signed(a_out_l), 500);
        checkOutput("t4_valid_c8", int'(a_valid), 1);
        checkOutput("t4_overrun_c8", int'(a_overrun), 1);
        applyStimulus(3000, 400, 0, 0);
        tick(1);
        push_a(500, 100);
        applyStimulus(3000, 400, 0, 1);
        tick(1);
        checkOutput("t4_valid_c10", int'(a_valid), 0);
        checkOutput("t4_overrun_c10", int'(a_overrun), 1);
        checkOutput("t4_out_l_hold", $signed(a_out_l), 500);
        applyStimulus(3000, 400, 0, 0);
        tick(2);
        checkOutput("t4_valid_c12", int'(a_valid), 1);
        checkOutput("t4_out_l_c12", $signed(a_out_l), 750);
        checkOutput("t4_overrun_c12", int'(a_overrun), 1);
        tick(1);
        checkOutput("t4_valid_c13", int'(a_valid), 1);

        // Reset mid-window with a pending sample and overrun set.
        applyStimulus(1000, 400, 0, 1);
        reset_a();
        push_a(250, 100);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("t5_valid_restart", int'(a_valid), (k == 3) ? 1 : 0);
        end
        tick(1);

        // Transfer and new sample in the same cycle must not set overrun.
        reset_a();
        applyStimulus(1000, 400, 0, 0);
        tick(4);
        checkOutput("t4b_valid_c4", int'(a_valid), 1);
        applyStimulus(2000, 400, 0, 0);
        tick(3);
        checkOutput("t4b_valid_c7", int'(a_valid), 1);
        push_a(250, 100);
        push_a(500, 100);
        applyStimulus(2000, 400, 0, 1);
        tick(1);
        checkOutput("t4b_valid_c8", int'(a_valid), 1);
        checkOutput("t4b_overrun_c8", int'(a_overrun), 0);
        checkOutput("t4b_out_l_c8", $signed(a_out_l), 500);
        tick(1);
        checkOutput("t4b_valid_c9", int'(a_valid), 0);
        applyStimulus(0, 0, 0, 0);
        rst_a = 1'b1;

        // Long window, alternating full-scale input cancels to zero.
        b_gain  = 2'd1;
        b_ready = 1'b1;
        rst_b   = 1'b1;
        tick(1);
        rst_b = 1'b0;
        for (int k = 0; k <= 2048; k++) begin
            b_in_l = (k % 2 == 0) ? 18'(131071) : 18'(-131071);
            b_in_r = (k % 2 == 0) ? 18'(-131071) : 18'(131071);
            if (k % 1024 == 0 && k < 2048) qb.push_back('{16'd0, 16'd0});
            tick(1);
            if ((k + 1) % 1024 == 0) begin
                checkOutput("t6_valid_end", int'(b_valid), 1);
            end else if ((k + 1) % 256 == 0) begin
                checkOutput("t6_valid_mid", int'(b_valid), 0);
            end
        end

        checkOutput("qa_drained", qa.size(), 0);
        checkOutput("qb_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
